// File: rtl/radio_pkg.sv
// ============================================================================
// Module      : radio_pkg
// Description : Shared types, tuning constants and K clamp helper for radio_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package radio_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      SETTLE = 1'b1
   } tune_state_t;

   localparam int          DDS_W       = 32;
   localparam logic [31:0] c_k_default = 32'h1999_999A;
   localparam logic [31:0] c_k_step    = 32'h0005_5555;
   localparam logic [31:0] c_k_min     = 32'h1333_3333;
   localparam logic [31:0] c_k_max     = 32'h2000_0000;

   // v carries one guard bit so step overflow past hi is still seen as "above".
   function automatic logic [DDS_W-1:0] clamp_k(input logic [DDS_W:0]   v,
                                                input logic [DDS_W-1:0] lo,
                                                input logic [DDS_W-1:0] hi);
      if (v < {1'b0, lo})
         return lo;
      else if (v > {1'b0, hi})
         return hi;
      else
         return v[DDS_W-1:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/ce_divider.sv
// ============================================================================
// Module      : ce_divider
// Description : Modulo-N counter advancing on en_in; en_out marks the wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ce_divider #(
   parameter int N = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_in,
   output logic en_out
);

   localparam int             W      = (N > 1) ? $clog2(N) : 1;
   localparam logic [W-1:0]   c_last = W'(N - 1);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= '0;
      else if (en_in)
         r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
   end

   assign en_out = en_in & (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/radio_ctrl.sv
// ============================================================================
// Module      : radio_ctrl
// Description : Clock-enable sequencer, DDS K tuning and post-retune audio mute.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module radio_ctrl
   import radio_pkg::*;
#(
   parameter int                   WIDTH_DDS = DDS_W,
   parameter int                   R1A       = 5,
   parameter int                   R1B       = 50,
   parameter int                   R2        = 30,
   parameter int                   SETTLE_A  = 8,
   parameter logic [WIDTH_DDS-1:0] K_DEFAULT = c_k_default,
   parameter logic [WIDTH_DDS-1:0] K_STEP    = c_k_step,
   parameter logic [WIDTH_DDS-1:0] K_MIN     = c_k_min,
   parameter logic [WIDTH_DDS-1:0] K_MAX     = c_k_max
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  tune_req,
   input  logic [WIDTH_DDS-1:0]  tune_k,
   input  logic                  tune_up,
   input  logic                  tune_down,
   output logic                  tune_ack,
   output logic                  busy,
   output logic                  en1,
   output logic                  en_b,
   output logic                  en_a,
   output logic [WIDTH_DDS-1:0]  K,
   input  logic signed [15:0]    demod_in,
   output logic signed [15:0]    audio_out,
   output logic                  audio_valid
);

   localparam int            SW           = $clog2(SETTLE_A + 1);
   localparam logic [SW-1:0] c_settle_load = SW'(SETTLE_A);
   localparam logic [SW-1:0] c_settle_last = SW'(1);

   logic                     w_en1, w_en_b, w_en_a;
   logic                     w_step, w_accept, w_busy;
   logic [WIDTH_DDS:0]       w_sum, w_diff;
   logic [WIDTH_DDS-1:0]     w_k_next;
   tune_state_t              r_state, w_state_next;
   logic [SW-1:0]            r_settle_cnt;
   logic [WIDTH_DDS-1:0]     r_k;
   logic                     r_tune_ack;
   logic signed [15:0]       r_audio;
   logic                     r_audio_valid;

   ce_divider #(.N(R1A)) u_div_1 (.clk(clk), .rst_n(reset), .en_in(1'b1),  .en_out(w_en1));
   ce_divider #(.N(R1B)) u_div_b (.clk(clk), .rst_n(reset), .en_in(w_en1), .en_out(w_en_b));
   ce_divider #(.N(R2))  u_div_a (.clk(clk), .rst_n(reset), .en_in(w_en_b), .en_out(w_en_a));

   // Conflicting up+down cancels out; tune_req overrides any step.
   assign w_step   = tune_up ^ tune_down;
   assign w_accept = tune_req | w_step;
   assign w_sum    = {1'b0, r_k} + {1'b0, K_STEP};
   assign w_diff   = {1'b0, r_k} - {1'b0, K_STEP};

   always_comb begin
      w_k_next = r_k;
      if (tune_req)
         w_k_next = clamp_k({1'b0, tune_k}, K_MIN, K_MAX);
      else if (w_step && tune_up)
         w_k_next = clamp_k(w_sum, K_MIN, K_MAX);
      else if (w_step)
         w_k_next = w_diff[WIDTH_DDS] ? K_MIN : clamp_k(w_diff, K_MIN, K_MAX);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= SETTLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_next = SETTLE;
         SETTLE:  if (!w_accept && w_en_a && (r_settle_cnt == c_settle_last))
                     w_state_next = IDLE;
         default: w_state_next = SETTLE;
      endcase
   end

   always_comb begin
      w_busy = (r_state == SETTLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_settle_cnt  <= c_settle_load;
         r_k           <= K_DEFAULT;
         r_tune_ack    <= 1'b0;
         r_audio       <= '0;
         r_audio_valid <= 1'b0;
      end else begin
         if (w_accept)
            r_settle_cnt <= c_settle_load;
         else if ((r_state == SETTLE) && w_en_a)
            r_settle_cnt <= r_settle_cnt - 1'b1;
         r_k           <= w_k_next;
         r_tune_ack    <= w_accept;
         // The en_a that ends settling still sees busy=1 and emits silence.
         if (w_en_a)
            r_audio <= w_busy ? '0 : demod_in;
         r_audio_valid <= w_en_a;
      end
   end

   assign tune_ack    = r_tune_ack;
   assign busy        = w_busy;
   assign en1         = w_en1;
   assign en_b        = w_en_b;
   assign en_a        = w_en_a;
   assign K           = r_k;
   assign audio_out   = r_audio;
   assign audio_valid = r_audio_valid;

endmodule

`default_nettype wire

// File: tb/tb_radio_ctrl.sv
// ============================================================================
// Module      : tb_radio_ctrl
// Description : Directed bench: full-rate enable timing plus a fast-divider instance for tuning/mute.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_radio_ctrl;

   localparam logic [31:0] c_kdef  = 32'h1999_999A;
   localparam logic [31:0] c_kmin  = 32'h1333_3333;
   localparam logic [31:0] c_kmax  = 32'h2000_0000;
   localparam logic [31:0] c_ktune = 32'h1A00_0000;
   localparam logic [31:0] c_live  = 32'd1000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // full-rate instance
   logic               f_reset, f_req, f_up, f_dn, f_ack, f_busy, f_en1, f_en_b, f_en_a, f_valid;
   logic [31:0]        f_tune_k, f_k;
   logic signed [15:0] f_demod, f_audio;

   // fast-divider instance: en_a every 24 clk
   logic               s_reset, s_req, s_up, s_dn, s_ack, s_busy, s_en1, s_en_b, s_en_a, s_valid;
   logic [31:0]        s_tune_k, s_k;
   logic signed [15:0] s_demod, s_audio;

   int n_asserts = 0;
   int n_fail    = 0;

   radio_ctrl u_dut_full (
      .clk(clk), .reset(f_reset), .tune_req(f_req), .tune_k(f_tune_k), .tune_up(f_up),
      .tune_down(f_dn), .tune_ack(f_ack), .busy(f_busy), .en1(f_en1), .en_b(f_en_b),
      .en_a(f_en_a), .K(f_k), .demod_in(f_demod), .audio_out(f_audio), .audio_valid(f_valid)
   );

   radio_ctrl #(.R1A(2), .R1B(3), .R2(4)) u_dut_fast (
      .clk(clk), .reset(s_reset), .tune_req(s_req), .tune_k(s_tune_k), .tune_up(s_up),
      .tune_down(s_dn), .tune_ack(s_ack), .busy(s_busy), .en1(s_en1), .en_b(s_en_b),
      .en_a(s_en_a), .K(s_k), .demod_in(s_demod), .audio_out(s_audio), .audio_valid(s_valid)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string tag);
      int b = 0;
      do begin
         tick();
         b++;
      end while (s_valid !== 1'b1 && b < 400);
      chk({tag, "_valid_seen"}, {31'd0, s_valid}, 32'd1);
   endtask

   task automatic wait_en_a();
      int b = 0;
      while (s_en_a !== 1'b1 && b < 400) begin
         tick();
         b++;
      end
      chk("en_a_seen", {31'd0, s_en_a}, 32'd1);
   endtask

   // Applies one command for a single cycle and checks K/ack on the following sample.
   task automatic cmd(input string tag, input logic req, input logic up, input logic dn,
                      input logic [31:0] kin, input logic [31:0] k_exp, input logic ack_exp);
      s_req = req; s_up = up; s_dn = dn; s_tune_k = kin;
      tick();
      s_req = 1'b0; s_up = 1'b0; s_dn = 1'b0;
      chk({tag, "_K"},   s_k, k_exp);
      chk({tag, "_ack"}, {31'd0, s_ack}, {31'd0, ack_exp});
   endtask

   task automatic settle_seq(input string tag);
      for (int n = 1; n <= 9; n++) begin
         wait_valid(tag);
         chk({tag, "_audio"}, 32'($signed(s_audio)), (n <= 8) ? 32'd0 : c_live);
         if (n == 7) chk({tag, "_busy_before_end"}, {31'd0, s_busy}, 32'd1);
         if (n == 8) chk({tag, "_busy_after_end"},  {31'd0, s_busy}, 32'd0);
      end
   endtask

   initial begin
      int en1_err, enb_err, orphan_a, na, first_a, second_a;
      f_reset = 1'b0; f_req = 1'b0; f_up = 1'b0; f_dn = 1'b0; f_tune_k = '0; f_demod = '0;
      s_reset = 1'b0; s_req = 1'b0; s_up = 1'b0; s_dn = 1'b0; s_tune_k = '0; s_demod = 16'sd1000;
      tick();
      tick();

      chk("rst_K",     f_k, c_kdef);
      chk("rst_busy",  {31'd0, f_busy}, 32'd1);
      chk("rst_ack",   {31'd0, f_ack}, 32'd0);
      chk("rst_en1",   {31'd0, f_en1}, 32'd0);
      chk("rst_valid", {31'd0, f_valid}, 32'd0);
      chk("rst_audio", 32'($signed(f_audio)), 32'd0);

      // Enable timing at full ratios; index 0 is the cycle just after release.
      f_reset = 1'b1;
      en1_err = 0; enb_err = 0; orphan_a = 0; na = 0; first_a = -1; second_a = -1;
      for (int i = 0; i < 15000; i++) begin
         if (f_en1  !== ((i % 5)   == 4))   en1_err++;
         if (f_en_b !== ((i % 250) == 249)) enb_err++;
         if (f_en_a === 1'b1 && f_en_b !== 1'b1) orphan_a++;
         if (f_en_a === 1'b1) begin
            if (na == 0) first_a = i;
            else if (na == 1) second_a = i;
            na++;
         end
         tick();
      end
      chk("en1_pattern_errs",   32'(en1_err), 32'd0);
      chk("en_b_pattern_errs",  32'(enb_err), 32'd0);
      chk("en_a_without_en_b",  32'(orphan_a), 32'd0);
      chk("en_a_count",         32'(na), 32'd2);
      chk("en_a_first_index",   32'(first_a), 32'd7499);
      chk("en_a_second_index",  32'(second_a), 32'd14999);

      // Post-reset mute on the fast instance.
      s_reset = 1'b1;
      chk("fast_rst_busy", {31'd0, s_busy}, 32'd1);
      settle_seq("reset_settle");

      // Retune from IDLE right after an en_a.
      cmd("tune_load", 1'b1, 1'b0, 1'b0, c_ktune, c_ktune, 1'b1);
      chk("tune_load_busy", {31'd0, s_busy}, 32'd1);
      tick();
      chk("tune_ack_single", {31'd0, s_ack}, 32'd0);
      settle_seq("retune_settle");

      // Saturation and clamping.
      cmd("load_near_max",  1'b1, 1'b0, 1'b0, 32'h1FFF_0000, 32'h1FFF_0000, 1'b1);
      cmd("up_saturate",    1'b0, 1'b1, 1'b0, 32'h0,         c_kmax,        1'b1);
      cmd("up_at_max",      1'b0, 1'b1, 1'b0, 32'h0,         c_kmax,        1'b1);
      cmd("down_from_max",  1'b0, 1'b0, 1'b1, 32'h0,         32'h1FFA_AAAB, 1'b1);
      cmd("load_below_min", 1'b1, 1'b0, 1'b0, 32'h1000_0000, c_kmin,        1'b1);
      cmd("down_at_min",    1'b0, 1'b0, 1'b1, 32'h0,         c_kmin,        1'b1);
      cmd("load_above_max", 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, c_kmax,        1'b1);
      cmd("load_near_min",  1'b1, 1'b0, 1'b0, 32'h1335_0000, 32'h1335_0000, 1'b1);
      cmd("down_saturate",  1'b0, 1'b0, 1'b1, 32'h0,         c_kmin,        1'b1);

      // Conflicting steps, then request priority over step.
      cmd("up_and_down",    1'b0, 1'b1, 1'b1, 32'h0,   c_kmin,  1'b0);
      cmd("req_over_up",    1'b1, 1'b1, 1'b0, c_ktune, c_ktune, 1'b1);

      // Command landing on the en_a that would end settling.
      for (int n = 1; n <= 7; n++) begin
         wait_en_a();
         tick();
      end
      wait_en_a();
      chk("pre_end_busy", {31'd0, s_busy}, 32'd1);
      s_req = 1'b1; s_tune_k = 32'h1C00_0000;
      tick();
      s_req = 1'b0;
      chk("collide_ack",   {31'd0, s_ack}, 32'd1);
      chk("collide_K",     s_k, 32'h1C00_0000);
      chk("collide_busy",  {31'd0, s_busy}, 32'd1);
      chk("collide_audio", 32'($signed(s_audio)), 32'd0);
      tick();
      chk("collide_still_settle", {31'd0, s_busy}, 32'd1);
      settle_seq("restart_settle");

      // Reset asserted mid-settle returns everything to reset values.
      cmd("pre_reset_tune", 1'b1, 1'b0, 1'b0, c_ktune, c_ktune, 1'b1);
      tick();
      tick();
      s_reset = 1'b0;
      #1;
      chk("midrst_K",     s_k, c_kdef);
      chk("midrst_audio", 32'($signed(s_audio)), 32'd0);
      chk("midrst_busy",  {31'd0, s_busy}, 32'd1);
      chk("midrst_ack",   {31'd0, s_ack}, 32'd0);
      chk("midrst_valid", {31'd0, s_valid}, 32'd0);
      chk("midrst_en1",   {31'd0, s_en1}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
